// File: rtl/aes_stream_pkg.sv
// Shared stream constants for the AES block path: word/block geometry and the
// assembly-side state encoding used by the block packer.
package aes_stream_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int WORDS   = BLOCK_W / WORD_W;
    localparam int CNT_W   = 5;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/aes_512_block_packer.sv
// Packs 32-bit plaintext words big-endian into 512-bit blocks for the AES
// encryptor, with a separate assembly buffer and output register.
module aes_512_block_packer
    import aes_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [0:WORD_W-1]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [0:BLOCK_W-1]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [CNT_W-1:0]     out_nwords
);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               last_flag_reg;
    logic [0:WORD_W-1]  slot_reg [WORDS];
    logic [0:BLOCK_W-1] asm_flat;

    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic [CNT_W-1:0]   out_nwords_reg;
    logic [0:BLOCK_W-1] out_data_reg;

    logic accept;
    logic block_done;
    logic xfer;

    // in_ready_reg is only ever high in FILL, so it doubles as the accept gate.
    assign accept     = in_valid && in_ready_reg;
    assign block_done = accept && ((cnt_reg == CNT_W'(WORDS - 1)) || in_last);
    assign xfer       = (state_reg == HOLD) && (!out_valid_reg || out_ready);

    // Slot 0 lands in the most significant (lowest-numbered) bits.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
            assign asm_flat[gi*WORD_W +: WORD_W] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FILL;
            cnt_reg        <= '0;
            last_flag_reg  <= 1'b0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_nwords_reg <= '0;
            out_data_reg   <= '0;
            for (int i = 0; i < WORDS; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                FILL: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        for (int i = 0; i < WORDS; i++) begin
                            if (cnt_reg == CNT_W'(i)) begin
                                slot_reg[i] <= in_data;
                            end
                        end
                        if (block_done) begin
                            state_reg     <= HOLD;
                            last_flag_reg <= in_last;
                            in_ready_reg  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    in_ready_reg <= 1'b0;
                    if (xfer) begin
                        // Clearing here is what zero-pads the next short block.
                        for (int i = 0; i < WORDS; i++) begin
                            slot_reg[i] <= '0;
                        end
                        cnt_reg      <= '0;
                        state_reg    <= FILL;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase

            // A HOLD transfer overrides a drain so blocks stream without a bubble.
            if (xfer) begin
                out_data_reg   <= asm_flat;
                out_nwords_reg <= cnt_reg;
                out_last_reg   <= last_flag_reg;
                out_valid_reg  <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign out_nwords = out_nwords_reg;
    assign out_data   = out_data_reg;

endmodule

// File: tb/tb_aes_512_block_packer.sv
// Scoreboard bench for the 512-bit block packer: expected blocks are queued as
// words are accepted and checked as the packer hands blocks out.
module tb_aes_512_block_packer;

    typedef struct {
        logic [0:511] data;
        logic [4:0]   nwords;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [0:31]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [0:511] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic [4:0]   out_nwords;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int accept_cycle = 0;

    blk_t         exp_q[$];
    logic [0:511] mdl_buf = '0;
    int           mdl_cnt = 0;

    logic [0:511] held_data;
    logic [4:0]   held_nwords;
    logic         held_last;
    bit           held_pending = 0;

    aes_512_block_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_nwords (out_nwords)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Output monitor: stability while stalled, scoreboard on each handoff.
    always @(negedge clk) begin
        if (out_valid) begin
            if (held_pending) begin
                n_tests++;
                if (out_data !== held_data || out_nwords !== held_nwords || out_last !== held_last) begin
                    n_fail++;
                    $display("FAIL hold_stable: got nwords=%0d last=%0b w0=%h, held nwords=%0d last=%0b w0=%h",
                             out_nwords, out_last, out_data[0:31], held_nwords, held_last, held_data[0:31]);
                end
            end
            if (!out_ready) begin
                held_pending = 1;
                held_data    = out_data;
                held_nwords  = out_nwords;
                held_last    = out_last;
            end else begin
                held_pending = 0;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_block: got nwords=%0d w0=%h, required no block",
                             out_nwords, out_data[0:31]);
                end else begin
                    blk_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_nwords !== e.nwords || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL block: got nwords=%0d last=%0b w0=%h w15=%h, required nwords=%0d last=%0b w0=%h w15=%h",
                                 out_nwords, out_last, out_data[0:31], out_data[480:511],
                                 e.nwords, e.last, e.data[0:31], e.data[480:511]);
                    end else begin
                        $display("[TB] block ok: nwords=%0d last=%0b w0=%h", out_nwords, out_last, out_data[0:31]);
                    end
                end
            end
        end else begin
            held_pending = 0;
        end
    end

    task automatic model_clear();
        exp_q.delete();
        mdl_buf = '0;
        mdl_cnt = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int  waited = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else if (waited > 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: word %h not accepted in %0d cycles, required acceptance", d, waited);
                in_valid = 1'b0;
                return;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        accept_cycle = cycle;
        mdl_buf[mdl_cnt*32 +: 32] = d;
        mdl_cnt++;
        if (mdl_cnt == 16 || last) begin
            blk_t b;
            b.data   = mdl_buf;
            b.nwords = 5'(mdl_cnt);
            b.last   = last;
            exp_q.push_back(b);
            mdl_buf = '0;
            mdl_cnt = 0;
        end
        $display("[TB] word accepted: %h last=%0b cycle=%0d", d, last, accept_cycle);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain: %0d blocks still pending, out_valid=%0b, required 0 and 0", exp_q.size(), out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0 ||
            out_nwords !== 5'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL %s: valid=%0b ready=%0b last=%0b nwords=%0d w0=%h, required all zero",
                     tag, out_valid, in_ready, out_last, out_nwords, out_data[0:31]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: in_ready=%0b out_valid=%0b, required 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_full_block();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_word(32'(i), i == 15);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_edge: out_valid=%0b in_ready=%0b, required 0 and 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        idle();
        n_tests++;
        if (out_valid !== 1'b1 || out_data[0:31] !== 32'h0 || out_data[480:511] !== 32'hF ||
            out_nwords !== 5'd16 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL full_latency: valid=%0b w0=%h w15=%h nwords=%0d last=%0b, required 1 0 f 16 1",
                     out_valid, out_data[0:31], out_data[480:511], out_nwords, out_last);
        end
        wait_drain();
    endtask

    task automatic test_short_block();
        logic [0:95] exp_head;
        exp_head = {32'hAABBCCDD, 32'h11223344, 32'h55667788};
        out_ready = 1'b1;
        send_word(32'hAABBCCDD, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b1);
        idle();
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data[0:95] !== exp_head || out_data[96:511] !== '0 ||
            out_nwords !== 5'd3 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL short_block: valid=%0b head=%h tail_zero=%0b nwords=%0d last=%0b, required 1 %h 1 3 1",
                     out_valid, out_data[0:95], out_data[96:511] == '0, out_nwords, out_last, exp_head);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) send_word(32'h100 + 32'(i), 1'b0);
        idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_nwords !== 5'd16 || out_data[0:31] !== 32'h100) begin
                n_fail++;
                $display("FAIL bp_hold: in_ready=%0b valid=%0b nwords=%0d w0=%h, required 0 1 16 00000100",
                         in_ready, out_valid, out_nwords, out_data[0:31]);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 32; i < 40; i++) send_word(32'h100 + 32'(i), i == 39);
        idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int c16 = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send_word(32'hA5A50000 ^ 32'(i), i == 31);
            if (i == 15) begin
                c16 = accept_cycle;
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_bubble: in_ready=%0b after word 16, required 0", in_ready);
                end
            end
            if (i == 16) begin
                n_tests++;
                if (accept_cycle - c16 != 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap: %0d cycles between word 16 and 17, required 2", accept_cycle - c16);
                end
            end
        end
        idle();
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_word(32'h5000 + 32'(i), 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        model_clear();
        @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_partial: out_valid=%0b, required 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send_word(32'hDEADBEEF, 1'b1);
        idle();
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data[0:31] !== 32'hDEADBEEF || out_data[32:511] !== '0 || out_nwords !== 5'd1) begin
            n_fail++;
            $display("FAIL reset_recover: valid=%0b w0=%h rest_zero=%0b nwords=%0d, required 1 deadbeef 1 1",
                     out_valid, out_data[0:31], out_data[32:511] == '0, out_nwords);
        end
        wait_drain();
    endtask

    task automatic test_stall_second();
        out_ready = 1'b0;
        send_word(32'hCAFE0001, 1'b1);
        idle();
        @(posedge clk);
        #1;
        send_word(32'hB0B00000, 1'b0);
        send_word(32'hB0B00001, 1'b1);
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data[0:31] !== 32'hCAFE0001 || out_nwords !== 5'd1) begin
                n_fail++;
                $display("FAIL stall_second: in_ready=%0b valid=%0b w0=%h nwords=%0d, required 0 1 cafe0001 1",
                         in_ready, out_valid, out_data[0:31], out_nwords);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data[0:31] !== 32'hB0B00000 || out_nwords !== 5'd2 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_no_bubble: valid=%0b w0=%h nwords=%0d last=%0b, required 1 b0b00000 2 1",
                     out_valid, out_data[0:31], out_nwords, out_last);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stall_second();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected blocks never produced, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
